// File: rtl/sseg_pkg.sv
// Shared types, glyph table and polarity helper for the seven-segment scan driver.
// Glyphs are stored active-low in {g,f,e,d,c,b,a} order.
package sseg_pkg;

  typedef logic [6:0] seg_t;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } scan_state_e;

  localparam seg_t SEG_BLANK = 7'b1111111;

  localparam seg_t FONT [16] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000,  // 9
    7'b0001000,  // A
    7'b0000011,  // b
    7'b1000110,  // C
    7'b0100001,  // d
    7'b0000110,  // E
    7'b0001110   // F
  };

  // Converts one internally active-low pin level to the board's pin polarity.
  function automatic logic polarity(input logic level_n, input logic active_low);
    return active_low ? level_n : ~level_n;
  endfunction

endpackage

// File: rtl/sseg_font_rom.sv
// Combinational nibble-to-glyph lookup; output is active-low gfedcba.
module sseg_font_rom
  import sseg_pkg::*;
(
  input  logic [3:0] nib_i,
  output seg_t       seg_o
);

  assign seg_o = FONT[nib_i];

endmodule

// File: rtl/sseg_scan_driver.sv
// Time-multiplexed N-digit common-anode seven-segment driver with double-buffered
// display contents, blanking interval per digit slot and leading-zero suppression.
module sseg_scan_driver
  import sseg_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int DIGIT_CYCLES = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] hex_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    lz_en,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              sseg,
  output logic                    dp,
  output logic                    frame_done
);

  localparam int CNT_W = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic             POL_LOW    = (ACTIVE_LOW != 0);

  // Deasserted pin levels after polarity is applied.
  localparam logic PIN_OFF = POL_LOW;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  scan_state_e      state_q, state_d;

  logic [4*NUM_DIGITS-1:0] pend_hex_q, pend_hex_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic [NUM_DIGITS-1:0]   pend_en_q, pend_en_d;
  logic                    pend_valid_q, pend_valid_d;

  logic [4*NUM_DIGITS-1:0] shd_hex_q, shd_hex_d;
  logic [NUM_DIGITS-1:0]   shd_dp_q, shd_dp_d;
  logic [NUM_DIGITS-1:0]   shd_en_q, shd_en_d;

  logic [NUM_DIGITS-1:0]   an_q, an_d;
  seg_t                    sseg_q, sseg_d;
  logic                    dp_q, dp_d;

  logic slot_last;
  logic frame_end;

  assign slot_last = (cnt_q == CNT_LAST);
  assign frame_end = slot_last && (idx_q == IDX_LAST);

  // ---------------------------------------------------------------------------
  // Slot counter and digit index
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    idx_d = idx_q;
    if (slot_last) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Per-slot BLANK/SHOW state; tracks the counter so that state_q is BLANK
  // exactly while cnt_q < BLANK_CYCLES.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BLANK: if (cnt_q == BLANK_LAST) state_d = ST_SHOW;
      ST_SHOW:  if (slot_last)           state_d = ST_BLANK;
      default:  state_d = ST_BLANK;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Pending/shadow double buffer. The shadow only changes at the frame
  // boundary, so a frame is never drawn from two different loads.
  // ---------------------------------------------------------------------------
  always_comb begin
    pend_hex_d   = pend_hex_q;
    pend_dp_d    = pend_dp_q;
    pend_en_d    = pend_en_q;
    pend_valid_d = pend_valid_q;
    shd_hex_d    = shd_hex_q;
    shd_dp_d     = shd_dp_q;
    shd_en_d     = shd_en_q;

    if (load) begin
      pend_hex_d   = hex_in;
      pend_dp_d    = dp_in;
      pend_en_d    = digit_en;
      pend_valid_d = 1'b1;
    end

    if (frame_end) begin
      if (load) begin
        shd_hex_d    = hex_in;
        shd_dp_d     = dp_in;
        shd_en_d     = digit_en;
        pend_valid_d = 1'b0;
      end else if (pend_valid_q) begin
        shd_hex_d    = pend_hex_q;
        shd_dp_d     = pend_dp_q;
        shd_en_d     = pend_en_q;
        pend_valid_d = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Leading-zero detection: zero_from[i] is set when every nibble and dp bit
  // from position i up to the most significant digit is clear.
  // ---------------------------------------------------------------------------
  logic [3:0]          nib [NUM_DIGITS];
  logic [NUM_DIGITS:0] zero_from;

  assign zero_from[NUM_DIGITS] = 1'b1;

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    assign nib[gi]       = shd_hex_q[4*gi +: 4];
    assign zero_from[gi] = zero_from[gi+1] && (nib[gi] == 4'h0) && !shd_dp_q[gi];
  end

  logic [3:0] cur_nib;
  logic       cur_en;
  logic       cur_dp;
  logic       cur_sup;
  logic       cur_blank;
  seg_t       font_seg;

  assign cur_nib   = nib[idx_q];
  assign cur_en    = shd_en_q[idx_q];
  assign cur_dp    = shd_dp_q[idx_q];
  assign cur_sup   = lz_en && (idx_q != '0) && zero_from[idx_q] && cur_en;
  assign cur_blank = !cur_en || cur_sup;

  sseg_font_rom u_font (
    .nib_i (cur_nib),
    .seg_o (font_seg)
  );

  // ---------------------------------------------------------------------------
  // Output decode, built active-low and then mapped to pin polarity.
  // ---------------------------------------------------------------------------
  logic [NUM_DIGITS-1:0] an_n;
  seg_t                  seg_n;
  logic                  dp_n;

  always_comb begin
    an_n  = '1;
    seg_n = SEG_BLANK;
    dp_n  = 1'b1;
    if (state_q == ST_SHOW) begin
      an_n[idx_q] = 1'b0;
      if (!cur_blank) begin
        seg_n = font_seg;
        dp_n  = ~cur_dp;
      end
    end

    for (int k = 0; k < NUM_DIGITS; k++) begin
      an_d[k] = polarity(an_n[k], POL_LOW);
    end
    for (int k = 0; k < 7; k++) begin
      sseg_d[k] = polarity(seg_n[k], POL_LOW);
    end
    dp_d = polarity(dp_n, POL_LOW);
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      state_q      <= ST_BLANK;
      pend_hex_q   <= '0;
      pend_dp_q    <= '0;
      pend_en_q    <= '0;
      pend_valid_q <= 1'b0;
      shd_hex_q    <= '0;
      shd_dp_q     <= '0;
      shd_en_q     <= '0;
      an_q         <= {NUM_DIGITS{PIN_OFF}};
      sseg_q       <= {7{PIN_OFF}};
      dp_q         <= PIN_OFF;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      state_q      <= state_d;
      pend_hex_q   <= pend_hex_d;
      pend_dp_q    <= pend_dp_d;
      pend_en_q    <= pend_en_d;
      pend_valid_q <= pend_valid_d;
      shd_hex_q    <= shd_hex_d;
      shd_dp_q     <= shd_dp_d;
      shd_en_q     <= shd_en_d;
      an_q         <= an_d;
      sseg_q       <= sseg_d;
      dp_q         <= dp_d;
    end
  end

  assign an         = an_q;
  assign sseg       = sseg_q;
  assign dp         = dp_q;
  assign frame_done = frame_end;

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Self-checking bench for sseg_scan_driver (4 digits, 4-cycle slots, 1 blank cycle):
// a frame-level reference model predicts every output cycle.
module tb_sseg_scan_driver;

  localparam int N  = 4;
  localparam int DC = 4;
  localparam int BC = 1;
  localparam int FR = N * DC;

  localparam logic [6:0] G_BLANK = 7'b1111111;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b0;
  logic        load     = 1'b0;
  logic        lz_en    = 1'b0;
  logic [15:0] hex_in   = '0;
  logic [3:0]  dp_in    = '0;
  logic [3:0]  digit_en = '0;
  logic [3:0]  an;
  logic [6:0]  sseg;
  logic        dp;
  logic        frame_done;

  int checks   = 0;
  int failures = 0;

  // Reference model: absolute scan position plus the frame being drawn and the
  // contents that the next frame will use.
  int          pos = 0;
  logic [15:0] show_hex = '0, next_hex = '0;
  logic [3:0]  show_dp  = '0, next_dp  = '0;
  logic [3:0]  show_en  = '0, next_en  = '0;
  logic [3:0]  exp_an   = 4'hF;
  logic [6:0]  exp_sseg = G_BLANK;
  logic        exp_dp   = 1'b1;
  logic        exp_fd   = 1'b0;

  always #5 clk = ~clk;

  sseg_scan_driver #(
    .NUM_DIGITS   (N),
    .DIGIT_CYCLES (DC),
    .BLANK_CYCLES (BC),
    .ACTIVE_LOW   (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .hex_in     (hex_in),
    .dp_in      (dp_in),
    .digit_en   (digit_en),
    .lz_en      (lz_en),
    .an         (an),
    .sseg       (sseg),
    .dp         (dp),
    .frame_done (frame_done)
  );

  function automatic logic [6:0] font(input logic [3:0] v);
    case (v)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  function automatic string obs();
    return $sformatf("got an=%b sseg=%b dp=%b fd=%b, expected an=%b sseg=%b dp=%b fd=%b",
                     an, sseg, dp, frame_done, exp_an, exp_sseg, exp_dp, exp_fd);
  endfunction

  task automatic model_reset();
    pos = 0;
    show_hex = '0; show_dp = '0; show_en = '0;
    next_hex = '0; next_dp = '0; next_en = '0;
    exp_an = 4'hF; exp_sseg = G_BLANK; exp_dp = 1'b1; exp_fd = 1'b0;
  endtask

  // Drives one clock with the current inputs and predicts the registered
  // outputs from the position the scan was in before the edge.
  task automatic tick(input logic ld);
    int   slot, dig;
    logic sup;
    load = ld;
    if (ld) $display("load pos=%0d hex=%h dp=%b en=%b lz=%b", pos, hex_in, dp_in, digit_en, lz_en);
    slot     = pos % DC;
    dig      = (pos / DC) % N;
    exp_an   = 4'hF;
    exp_sseg = G_BLANK;
    exp_dp   = 1'b1;
    if (slot >= BC) begin
      exp_an = ~(4'b0001 << dig);
      sup = lz_en && (dig > 0) && ((show_hex >> (4 * dig)) == 16'h0) && ((show_dp >> dig) == 4'h0);
      if (show_en[dig] && !sup) begin
        exp_sseg = font(show_hex[4*dig +: 4]);
        exp_dp   = ~show_dp[dig];
      end
    end
    if (ld) begin
      next_hex = hex_in; next_dp = dp_in; next_en = digit_en;
    end
    if (pos % FR == FR - 1) begin
      show_hex = next_hex; show_dp = next_dp; show_en = next_en;
    end
    pos++;
    exp_fd = (pos % FR == FR - 1);
    @(posedge clk);
    #1;
    load = 1'b0;
  endtask

  task automatic test_reset();
    #17;
    checks++;
    if ({an, sseg, dp, frame_done} !== {4'hF, G_BLANK, 1'b1, 1'b0}) begin
      failures++; $display("FAIL reset_initial got an=%b sseg=%b dp=%b fd=%b, expected 1111 1111111 1 0", an, sseg, dp, frame_done);
    end
    rst_n = 1'b1;
    model_reset();
    hex_in = 16'h8888; digit_en = 4'hF; dp_in = 4'h0;
    for (int k = 0; k < 22; k++) begin
      tick(k == 0);
      checks++;
      if ({an, sseg, dp, frame_done} !== {exp_an, exp_sseg, exp_dp, exp_fd}) begin
        failures++; $display("FAIL reset_run pos=%0d %s", pos, obs());
      end
      if (k == 1) begin
        checks++;
        if (an !== 4'b1110) begin
          failures++; $display("FAIL reset_first_show got an=%b, expected 1110", an);
        end
      end
    end
    // Asynchronous reset in the middle of a SHOW slot.
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({an, sseg, dp, frame_done} !== {4'hF, G_BLANK, 1'b1, 1'b0}) begin
      failures++; $display("FAIL reset_async got an=%b sseg=%b dp=%b fd=%b, expected 1111 1111111 1 0", an, sseg, dp, frame_done);
    end
    #2;
    rst_n = 1'b1;
    model_reset();
    for (int k = 0; k < 6; k++) begin
      tick(1'b0);
      checks++;
      if ({an, sseg, dp, frame_done} !== {exp_an, exp_sseg, exp_dp, exp_fd}) begin
        failures++; $display("FAIL reset_restart pos=%0d %s", pos, obs());
      end
      if (k == 1) begin
        checks++;
        if ({an, sseg} !== {4'b1110, G_BLANK}) begin
          failures++; $display("FAIL reset_restart_digit0 got an=%b sseg=%b, expected 1110 1111111", an, sseg);
        end
      end
    end
  endtask

  task automatic test_load_scan();
    logic [6:0] want [4];
    int fd_cnt, show_cnt, blank_cnt;
    want[0] = 7'b0001110; want[1] = 7'b0001000; want[2] = 7'b0100100; want[3] = 7'b1111001;
    fd_cnt = 0; show_cnt = 0; blank_cnt = 0;
    lz_en = 1'b0; hex_in = 16'h12AF; digit_en = 4'hF; dp_in = 4'h0;
    while (pos % FR != 0) begin
      tick(1'b0);
      checks++;
      if ({an, sseg, dp, frame_done} !== {exp_an, exp_sseg, exp_dp, exp_fd}) begin
        failures++; $display("FAIL load_scan_align pos=%0d %s", pos, obs());
      end
    end
    tick(1'b1);
    for (int k = 0; k < 2 * FR; k++) begin
      tick(1'b0);
      checks++;
      if ({an, sseg, dp, frame_done} !== {exp_an, exp_sseg, exp_dp, exp_fd}) begin
        failures++; $display("FAIL load_scan pos=%0d %s", pos, obs());
      end
      if (frame_done) fd_cnt++;
      if (k >= FR) begin
        if (an == 4'hF) blank_cnt++;
        for (int d = 0; d < N; d++) begin
          if (an == ~(4'b0001 << d)) begin
            show_cnt++;
            checks++;
            if ({sseg, dp} !== {want[d], 1'b1}) begin
              failures++; $display("FAIL load_scan_glyph digit=%0d got sseg=%b dp=%b, expected sseg=%b dp=1", d, sseg, dp, want[d]);
            end
          end
        end
      end
    end
    checks++;
    if (fd_cnt != 2) begin
      failures++; $display("FAIL load_scan_frame_done got %0d pulses in 32 cycles, expected 2", fd_cnt);
    end
    checks++;
    if (show_cnt != 12 || blank_cnt != 4) begin
      failures++; $display("FAIL load_scan_slots got show=%0d blank=%0d, expected show=12 blank=4", show_cnt, blank_cnt);
    end
  endtask

  task automatic test_no_tearing();
    int ones, twos;
    ones = 0; twos = 0;
    lz_en = 1'b0; hex_in = 16'h3456; digit_en = 4'hF; dp_in = 4'h0;
    while (pos % FR != 0) begin
      tick(1'b0);
      checks++;
      if ({an, sseg, dp, frame_done} !== {exp_an, exp_sseg, exp_dp, exp_fd}) begin
        failures++; $display("FAIL tearing_align pos=%0d %s", pos, obs());
      end
    end
    tick(1'b1);
    for (int k = 0; k < FR + 4; k++) begin
      tick(1'b0);
      checks++;
      if ({an, sseg, dp, frame_done} !== {exp_an, exp_sseg, exp_dp, exp_fd}) begin
        failures++; $display("FAIL tearing_prefill pos=%0d %s", pos, obs());
      end
    end
    // Scan is now in digit 1 of the frame drawing 3456.
    hex_in = 16'h1111;
    tick(1'b1);
    while (pos % FR != 9) begin
      tick(1'b0);
      checks++;
      if ({an, sseg, dp, frame_done} !== {exp_an, exp_sseg, exp_dp, exp_fd}) begin
        failures++; $display("FAIL tearing_mid pos=%0d %s", pos, obs());
      end
    end
    hex_in = 16'h2222;
    tick(1'b1);
    for (int k = 0; k < 2 * FR; k++) begin
      tick(1'b0);
      checks++;
      if ({an, sseg, dp, frame_done} !== {exp_an, exp_sseg, exp_dp, exp_fd}) begin
        failures++; $display("FAIL tearing pos=%0d %s", pos, obs());
      end
      if (an != 4'hF && sseg == 7'b1111001) ones++;
      if (an != 4'hF && sseg == 7'b0100100) twos++;
    end
    checks++;
    if (ones != 0 || twos < 12) begin
      failures++; $display("FAIL tearing_glyphs got ones=%0d twos=%0d, expected ones=0 twos>=12", ones, twos);
    end
  endtask

  task automatic test_lz();
    logic [15:0] hx [3];
    logic [3:0]  dx [3];
    int          want_nb [3];
    int          want_dp [3];
    int          nb, dpc;
    hx[0] = 16'h0050; dx[0] = 4'b0000; want_nb[0] = 6; want_dp[0] = 0;
    hx[1] = 16'h0000; dx[1] = 4'b0000; want_nb[1] = 3; want_dp[1] = 0;
    hx[2] = 16'h0050; dx[2] = 4'b0100; want_nb[2] = 9; want_dp[2] = 3;
    lz_en = 1'b1; digit_en = 4'hF;
    for (int c = 0; c < 3; c++) begin
      hex_in = hx[c]; dp_in = dx[c];
      while (pos % FR != 0) begin
        tick(1'b0);
        checks++;
        if ({an, sseg, dp, frame_done} !== {exp_an, exp_sseg, exp_dp, exp_fd}) begin
          failures++; $display("FAIL lz_align case=%0d pos=%0d %s", c, pos, obs());
        end
      end
      tick(1'b1);
      nb = 0; dpc = 0;
      for (int k = 0; k < 2 * FR; k++) begin
        tick(1'b0);
        checks++;
        if ({an, sseg, dp, frame_done} !== {exp_an, exp_sseg, exp_dp, exp_fd}) begin
          failures++; $display("FAIL lz case=%0d pos=%0d %s", c, pos, obs());
        end
        if (k >= FR && sseg != G_BLANK) nb++;
        if (k >= FR && dp == 1'b0) dpc++;
        if (k >= FR && an == 4'b0111) begin
          checks++;
          if ({sseg, dp} !== {G_BLANK, 1'b1}) begin
            failures++; $display("FAIL lz_digit3 case=%0d got sseg=%b dp=%b, expected 1111111 1", c, sseg, dp);
          end
        end
      end
      checks++;
      if (nb != want_nb[c] || dpc != want_dp[c]) begin
        failures++; $display("FAIL lz_counts case=%0d got lit=%0d dp=%0d, expected lit=%0d dp=%0d", c, nb, dpc, want_nb[c], want_dp[c]);
      end
    end
    lz_en = 1'b0;
  endtask

  task automatic test_enables();
    int lit, dark;
    lit = 0; dark = 0;
    lz_en = 1'b0; digit_en = 4'b1010; dp_in = 4'b1111; hex_in = 16'h8888;
    while (pos % FR != 0) begin
      tick(1'b0);
      checks++;
      if ({an, sseg, dp, frame_done} !== {exp_an, exp_sseg, exp_dp, exp_fd}) begin
        failures++; $display("FAIL enables_align pos=%0d %s", pos, obs());
      end
    end
    tick(1'b1);
    for (int k = 0; k < 2 * FR; k++) begin
      tick(1'b0);
      checks++;
      if ({an, sseg, dp, frame_done} !== {exp_an, exp_sseg, exp_dp, exp_fd}) begin
        failures++; $display("FAIL enables pos=%0d %s", pos, obs());
      end
      if (k >= FR && an != 4'hF && sseg == 7'b0000000 && dp == 1'b0) lit++;
      if (k >= FR && an != 4'hF && sseg == G_BLANK && dp == 1'b1) dark++;
    end
    checks++;
    if (lit != 6 || dark != 6) begin
      failures++; $display("FAIL enables_counts got lit=%0d dark=%0d, expected lit=6 dark=6", lit, dark);
    end
  endtask

  task automatic test_boundary();
    lz_en = 1'b0; digit_en = 4'hF; dp_in = 4'h0;
    while (pos % FR != FR - 1) begin
      tick(1'b0);
      checks++;
      if ({an, sseg, dp, frame_done} !== {exp_an, exp_sseg, exp_dp, exp_fd}) begin
        failures++; $display("FAIL boundary_align pos=%0d %s", pos, obs());
      end
    end
    checks++;
    if (frame_done !== 1'b1) begin
      failures++; $display("FAIL boundary_frame_done got %b, expected 1", frame_done);
    end
    hex_in = 16'hABCD;
    tick(1'b1);
    for (int k = 0; k < 2; k++) begin
      tick(1'b0);
      checks++;
      if ({an, sseg, dp, frame_done} !== {exp_an, exp_sseg, exp_dp, exp_fd}) begin
        failures++; $display("FAIL boundary pos=%0d %s", pos, obs());
      end
    end
    checks++;
    if ({an, sseg} !== {4'b1110, 7'b0100001}) begin
      failures++; $display("FAIL boundary_digit0 got an=%b sseg=%b, expected 1110 0100001", an, sseg);
    end
  endtask

  task automatic test_random();
    logic ld;
    for (int k = 0; k < 400; k++) begin
      ld = ($urandom_range(5) == 0);
      if (ld) begin
        hex_in   = 16'($urandom);
        dp_in    = 4'($urandom);
        digit_en = 4'($urandom);
        if ($urandom_range(2) == 0) hex_in = hex_in & 16'h00FF;
        if ($urandom_range(2) == 0) dp_in = dp_in & 4'b0001;
      end
      if ($urandom_range(9) == 0) lz_en = ~lz_en;
      tick(ld);
      checks++;
      if ({an, sseg, dp, frame_done} !== {exp_an, exp_sseg, exp_dp, exp_fd}) begin
        failures++; $display("FAIL random pos=%0d %s", pos, obs());
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_scan();
    test_no_tearing();
    test_lz();
    test_enables();
    test_boundary();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
